claw_motion_ctrl: RTL and testbench

Parametrised successor claw controller for the Gold Miner game layer. It swings the claw as a pendulum, extends it along the current angle when fire is pressed, and grabs on collision. It retracts at a speed set by the grabbed loot's weight, and auto-retracts empty at a depth limit or on an out-of-bounds hit. It sits between the keyboard/level FSM and the claw drawing/collision blocks, and drives the claw's top-left coordinates.

---
 rtl/claw_pkg.sv | 21 ++
 rtl/claw_polar_lut.sv | 31 +++
 rtl/claw_motion_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_claw_motion_ctrl.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/claw_pkg.sv
// Shared types and constants for the Gold Miner claw controller.
// Exports: claw_state_t, Q10 scale constants, loot weight classes.
package claw_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SWING,
      EXTEND,
      GRAB,
      RETRACT
   } claw_state_t;

   localparam int Q10_SCALE = 1024;
   localparam int Q10_MAX   = Q10_SCALE - 1;

   localparam logic [1:0] W_LIGHT  = 2'd0;
   localparam logic [1:0] W_MEDIUM = 2'd1;
   localparam logic [1:0] W_BIG    = 2'd2;
   localparam logic [1:0] W_HEAVY  = 2'd3;

endpackage

// File: rtl/claw_polar_lut.sv
// Combinational sin/cos lookup for 0..90 degrees, Q10, full scale 1023.
// Ports: alpha in (degrees, clamped to 90); sin_q10, cos_q10 out.
module claw_polar_lut (
   input  logic [6:0] alpha,
   output logic [9:0] sin_q10,
   output logic [9:0] cos_q10
);

   localparam int SIN_TAB [0:90] = '{
         0,  18,  36,  54,  71,  89, 107, 125, 143, 160,
       178, 195, 213, 230, 248, 265, 282, 299, 316, 333,
       350, 367, 384, 400, 416, 433, 449, 465, 481, 496,
       512, 527, 543, 558, 573, 587, 602, 616, 630, 644,
       658, 672, 685, 698, 711, 724, 737, 749, 761, 773,
       784, 796, 807, 818, 828, 839, 849, 859, 868, 878,
       887, 896, 904, 912, 920, 928, 935, 943, 949, 956,
       962, 968, 974, 979, 984, 989, 994, 998,1002,1005,
      1008,1011,1014,1016,1018,1020,1022,1023,1023,1023,
      1023
   };

   logic [6:0] a;

   // cos(a) is read as sin(90 - a)
   always_comb begin
      a       = (alpha > 7'd90) ? 7'd90 : alpha;
      sin_q10 = 10'(SIN_TAB[a]);
      cos_q10 = 10'(SIN_TAB[7'd90 - a]);
   end

endmodule

// File: rtl/claw_motion_ctrl.sv
// Claw controller: pendulum swing, fire-to-extend, grab, weighted retract.
// Ports: clk, reset, frame/level/fire/collision inputs; claw position and grab status out.
module claw_motion_ctrl
   import claw_pkg::*;
#(
   parameter int INITIAL_X    = 280,
   parameter int INITIAL_Y    = 50,
   parameter int MAX_ANGLE    = 80,
   parameter int RADIUS_SHIFT = 5,
   parameter int LINEAR_SHIFT = 3,
   parameter int WAIT_FRAMES  = 1,
   parameter int MAX_LENGTH   = 200,
   parameter int LEN_W        = 9,
   parameter int BASE_RETRACT = 8
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               startOfFrame,
   input  logic               start_level,
   input  logic               fire,
   input  logic               claw_collision,
   input  logic               out_of_bounds,
   input  logic [1:0]         load_weight,
   input  logic [3:0]         swing_speed,
   input  logic [3:0]         extend_speed,
   output logic signed [10:0] topLeftX,
   output logic signed [10:0] topLeftY,
   output logic               claw_returned,
   output logic               grabbed,
   output logic [1:0]         grab_weight,
   output logic               busy
);

   localparam int CNT_W = (WAIT_FRAMES > 1) ? $clog2(WAIT_FRAMES) : 1;
   localparam int LW1   = LEN_W + 1;
   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LENGTH);
   localparam logic [10:0] IX    = 11'(INITIAL_X);
   localparam logic [10:0] IY    = 11'(INITIAL_Y);
   localparam logic [10:0] RST_Y = 11'(INITIAL_Y + (Q10_MAX >> RADIUS_SHIFT));
   localparam logic [6:0]  MAX_A = 7'(MAX_ANGLE);

   claw_state_t      state;
   logic [6:0]       alpha;
   logic             dir_down;
   logic             side_left;
   logic             armed;
   logic [LEN_W-1:0] len;
   logic [CNT_W-1:0] cnt;
   logic             step;

   logic [9:0]       sin_q10, cos_q10;
   logic [9:0]       dx, dy, ux, uy;
   logic [10:0]      off_x, off_y;
   logic [8:0]       alpha_nxt;
   logic [LEN_W:0]   len_sum;
   logic [LEN_W-1:0] ext_len, rstep, ret_len;

   claw_polar_lut u_lut (
      .alpha   (alpha),
      .sin_q10 (sin_q10),
      .cos_q10 (cos_q10)
   );

   assign step = startOfFrame && (cnt == CNT_W'(WAIT_FRAMES - 1));
   assign busy = (state == EXTEND) || (state == GRAB) || (state == RETRACT);

   always_comb begin
      dx    = sin_q10 >> RADIUS_SHIFT;
      dy    = cos_q10 >> RADIUS_SHIFT;
      ux    = dx >> LINEAR_SHIFT;
      uy    = dy >> LINEAR_SHIFT;
      off_x = 11'(20'(ux) * 20'(len)) + 11'(dx);
      off_y = 11'(20'(uy) * 20'(len)) + 11'(dy);
   end

   // Signed 9-bit swing step; bit 8 set means it went below zero
   always_comb begin
      alpha_nxt = dir_down ? {2'b00, alpha} - 9'(swing_speed)
                           : {2'b00, alpha} + 9'(swing_speed);
      len_sum   = {1'b0, len} + LW1'(extend_speed);
      ext_len   = (len_sum >= LW1'(MAX_LENGTH)) ? MAX_L
                                               : len_sum[LEN_W-1:0];
      rstep     = LEN_W'(BASE_RETRACT) >> grab_weight;
      if (rstep == '0) rstep = LEN_W'(1);
      ret_len   = (len > rstep) ? len - rstep : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         topLeftX <= IX;
         topLeftY <= RST_Y;
      end else if (start_level) begin
         topLeftX <= IX;
         topLeftY <= RST_Y;
      end else begin
         topLeftX <= side_left ? IX - off_x : IX + off_x;
         topLeftY <= IY + off_y;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         alpha         <= '0;
         dir_down      <= 1'b0;
         side_left     <= 1'b0;
         armed         <= 1'b0;
         len           <= '0;
         cnt           <= '0;
         grabbed       <= 1'b0;
         grab_weight   <= W_LIGHT;
         claw_returned <= 1'b0;
      end else if (start_level) begin
         state         <= IDLE;
         alpha         <= '0;
         dir_down      <= 1'b0;
         side_left     <= 1'b0;
         armed         <= 1'b0;
         len           <= '0;
         cnt           <= '0;
         grabbed       <= 1'b0;
         grab_weight   <= W_LIGHT;
         claw_returned <= 1'b0;
      end else begin
         claw_returned <= 1'b0;
         // fire must be seen low before it can launch again
         if (!fire) armed <= 1'b1;
         if (startOfFrame) cnt <= step ? '0 : cnt + CNT_W'(1);
         unique case (state)
            IDLE: begin
               if (startOfFrame) state <= SWING;
            end
            SWING: begin
               if (fire && armed) begin
                  state <= EXTEND;
                  len   <= '0;
                  cnt   <= '0;
                  armed <= 1'b0;
               end else if (step) begin
                  if (alpha_nxt[8]) begin
                     alpha     <= '0;
                     dir_down  <= 1'b0;
                     side_left <= ~side_left;
                  end else if (alpha_nxt[7:0] > 8'(MAX_A)) begin
                     alpha    <= MAX_A;
                     dir_down <= 1'b1;
                  end else begin
                     alpha <= alpha_nxt[6:0];
                  end
               end
            end
            EXTEND: begin
               if (claw_collision) begin
                  state <= GRAB;
               end else if (out_of_bounds || len == MAX_L) begin
                  state   <= RETRACT;
                  grabbed <= 1'b0;
               end else if (step) begin
                  len <= ext_len;
               end
            end
            GRAB: begin
               grab_weight <= load_weight;
               grabbed     <= 1'b1;
               state       <= RETRACT;
            end
            RETRACT: begin
               if (len == '0) begin
                  claw_returned <= 1'b1;
                  grabbed       <= 1'b0;
                  state         <= SWING;
               end else if (step) begin
                  len <= ret_len;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_claw_motion_ctrl.sv
// Self-checking bench for claw_motion_ctrl against a geometric reference model.
// Drives frames, fire, collisions and level restarts; checks position and grab status.
module tb_claw_motion_ctrl;
   import claw_pkg::*;

   logic clk = 1'b0;
   logic reset, startOfFrame, start_level, fire;
   logic claw_collision, out_of_bounds;
   logic [1:0] load_weight;
   logic [3:0] swing_speed, extend_speed;
   logic signed [10:0] topLeftX, topLeftY;
   logic claw_returned, grabbed, busy;
   logic [1:0] grab_weight;

   int tests = 0;
   int fails = 0;
   int ret_cnt = 0;

   int m_alpha, m_len;
   bit m_down, m_left;

   claw_motion_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .startOfFrame   (startOfFrame),
      .start_level    (start_level),
      .fire           (fire),
      .claw_collision (claw_collision),
      .out_of_bounds  (out_of_bounds),
      .load_weight    (load_weight),
      .swing_speed    (swing_speed),
      .extend_speed   (extend_speed),
      .topLeftX       (topLeftX),
      .topLeftY       (topLeftY),
      .claw_returned  (claw_returned),
      .grabbed        (grabbed),
      .grab_weight    (grab_weight),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (claw_returned === 1'b1) ret_cnt <= ret_cnt + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, got 0 expected 1");
      $fatal(1, "watchdog");
   end

   function automatic int q10(input int deg);
      real v;
      int r;
      v = $floor(1024.0 * $sin(deg * 3.14159265358979 / 180.0) + 0.5);
      r = int'(v);
      if (r > 1023) r = 1023;
      return r;
   endfunction

   function automatic int exp_x();
      int dx, off;
      dx  = q10(m_alpha) / 32;
      off = dx + (dx / 8) * m_len;
      return m_left ? 280 - off : 280 + off;
   endfunction

   function automatic int exp_y();
      int dy;
      dy = q10(90 - m_alpha) / 32;
      return 50 + dy + (dy / 8) * m_len;
   endfunction

   task automatic model_swing(input int spd);
      int a;
      a = m_alpha + (m_down ? -spd : spd);
      if (a > 80) begin
         a = 80;
         m_down = 1'b1;
      end else if (a < 0) begin
         a = 0;
         m_down = 1'b0;
         m_left = !m_left;
      end
      m_alpha = a;
   endtask

   task automatic model_clear();
      m_alpha = 0;
      m_len   = 0;
      m_down  = 1'b0;
      m_left  = 1'b0;
   endtask

   task automatic frame();
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic restart();
      fire = 1'b0;
      claw_collision = 1'b0;
      out_of_bounds = 1'b0;
      start_level = 1'b1;
      @(negedge clk);
      start_level = 1'b0;
      frame();
      model_clear();
   endtask

   task automatic fire_pulse();
      fire = 1'b1;
      @(negedge clk);
      fire = 1'b0;
      @(negedge clk);
   endtask

   task automatic extend_n(input int n, input int s);
      extend_speed = 4'(s);
      for (int i = 0; i < n; i++) begin
         frame();
         m_len = (m_len + s > 200) ? 200 : m_len + s;
         tests++;
         if (int'(topLeftY) !== exp_y()) begin
            fails++;
            $display("FAIL ext_y[%0d]: got %0d expected %0d",
                     i, topLeftY, exp_y());
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      startOfFrame = 1'b0;
      start_level = 1'b0;
      fire = 1'b0;
      claw_collision = 1'b0;
      out_of_bounds = 1'b0;
      load_weight = 2'd0;
      swing_speed = 4'd4;
      extend_speed = 4'd2;
      repeat (3) @(negedge clk);
      tests++;
      if (topLeftX !== 11'sd280) begin
         fails++;
         $display("FAIL reset_x: got %0d expected 280", topLeftX);
      end
      tests++;
      if (topLeftY !== 11'sd81) begin
         fails++;
         $display("FAIL reset_y: got %0d expected 81", topLeftY);
      end
      tests++;
      if ({grabbed, busy, claw_returned, grab_weight} !== 5'b0) begin
         fails++;
         $display("FAIL reset_flags: got %b expected 00000",
                  {grabbed, busy, claw_returned, grab_weight});
      end
      reset = 1'b0;
      model_clear();
      frame();
      tests++;
      if (busy !== 1'b0 || topLeftX !== 11'sd280) begin
         fails++;
         $display("FAIL idle_to_swing: got busy=%b x=%0d expected 0 280",
                  busy, topLeftX);
      end
   endtask

   task automatic test_swing_basic();
      int prev;
      swing_speed = 4'd4;
      prev = int'(topLeftX);
      for (int i = 0; i < 3; i++) begin
         frame();
         model_swing(4);
         tests++;
         if (int'(topLeftX) !== exp_x() || int'(topLeftY) !== exp_y()) begin
            fails++;
            $display("FAIL swing_xy[%0d]: got %0d,%0d expected %0d,%0d",
                     i, topLeftX, topLeftY, exp_x(), exp_y());
         end
         tests++;
         if (int'(topLeftX) <= prev) begin
            fails++;
            $display("FAIL swing_mono[%0d]: got %0d expected above %0d",
                     i, topLeftX, prev);
         end
         prev = int'(topLeftX);
      end
   endtask

   task automatic test_swing_limit();
      int n;
      n = 0;
      swing_speed = 4'd4;
      while (!m_left && n < 100) begin
         frame();
         model_swing(4);
         n++;
         tests++;
         if (int'(topLeftX) !== exp_x() || int'(topLeftY) !== exp_y()) begin
            fails++;
            $display("FAIL limit_xy[%0d]: got %0d,%0d expected %0d,%0d",
                     n, topLeftX, topLeftY, exp_x(), exp_y());
         end
      end
      frame();
      model_swing(4);
      tests++;
      if (int'(topLeftX) >= 280 || int'(topLeftX) !== exp_x()) begin
         fails++;
         $display("FAIL left_side: got %0d expected %0d",
                  topLeftX, exp_x());
      end
   endtask

   task automatic test_swing_random();
      int spd;
      for (int i = 0; i < 40; i++) begin
         spd = int'($urandom_range(0, 15));
         swing_speed = 4'(spd);
         frame();
         model_swing(spd);
         tests++;
         if (int'(topLeftX) !== exp_x() || int'(topLeftY) !== exp_y()) begin
            fails++;
            $display("FAIL rswing[%0d] spd=%0d: got %0d,%0d expected %0d,%0d",
                     i, spd, topLeftX, topLeftY, exp_x(), exp_y());
         end
      end
   endtask

   task automatic test_extend_empty(input int s);
      int base, n;
      restart();
      fire = 1'b1;
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL ext_busy: got %b expected 1", busy);
      end
      extend_speed = 4'(s);
      n = 0;
      while (m_len < 200 && n < 300) begin
         extend_n(1, s);
         n++;
      end
      base = ret_cnt;
      n = 0;
      while (m_len > 0 && n < 300) begin
         frame();
         n++;
         m_len = (m_len > 8) ? m_len - 8 : 0;
         tests++;
         if (int'(topLeftY) !== exp_y() || grabbed !== 1'b0) begin
            fails++;
            $display("FAIL ret_y[%0d]: got %0d g=%b expected %0d g=0",
                     n, topLeftY, grabbed, exp_y());
         end
         if (m_len > 0) begin
            tests++;
            if (ret_cnt != base) begin
               fails++;
               $display("FAIL early_return[%0d]: got %0d expected 0",
                        n, ret_cnt - base);
            end
         end
      end
      tests++;
      if (ret_cnt - base != 1) begin
         fails++;
         $display("FAIL ret_pulse: got %0d cycles expected 1",
                  ret_cnt - base);
      end
      swing_speed = 4'd4;
      for (int i = 0; i < 2; i++) begin
         frame();
         model_swing(4);
         tests++;
         if (int'(topLeftX) !== exp_x() || int'(topLeftY) !== exp_y()) begin
            fails++;
            $display("FAIL held_fire[%0d]: got %0d,%0d expected %0d,%0d",
                     i, topLeftX, topLeftY, exp_x(), exp_y());
         end
      end
      fire = 1'b0;
   endtask

   task automatic grab_run(input int n, input int s, input int w);
      int r, base, k;
      restart();
      fire_pulse();
      extend_n(n, s);
      load_weight = 2'(w);
      claw_collision = 1'b1;
      @(negedge clk);
      claw_collision = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (grabbed !== 1'b1 || int'(grab_weight) !== w) begin
         fails++;
         $display("FAIL grab: got g=%b w=%0d expected g=1 w=%0d",
                  grabbed, grab_weight, w);
      end
      r = 8 >> w;
      if (r < 1) r = 1;
      base = ret_cnt;
      k = 0;
      while (m_len > 0 && k < 300) begin
         frame();
         k++;
         m_len = (m_len > r) ? m_len - r : 0;
         tests++;
         if (int'(topLeftY) !== exp_y()) begin
            fails++;
            $display("FAIL gret_y[%0d]: got %0d expected %0d",
                     k, topLeftY, exp_y());
         end
         if (m_len > 0) begin
            tests++;
            if (grabbed !== 1'b1 || ret_cnt != base) begin
               fails++;
               $display("FAIL gret_hold[%0d]: got g=%b r=%0d expected 1 0",
                        k, grabbed, ret_cnt - base);
            end
         end
      end
      tests++;
      if (ret_cnt - base != 1 || grabbed !== 1'b0) begin
         fails++;
         $display("FAIL grab_return: got r=%0d g=%b expected 1 0",
                  ret_cnt - base, grabbed);
      end
   endtask

   task automatic test_grab();
      int s;
      grab_run(10, 2, 3);
      for (int i = 0; i < 3; i++) begin
         s = int'($urandom_range(1, 15));
         grab_run(int'($urandom_range(1, 190 / s)), s,
                  int'($urandom_range(0, 3)));
      end
   endtask

   task automatic test_collision_priority();
      int base;
      restart();
      fire_pulse();
      extend_n(5, 3);
      load_weight = 2'd1;
      claw_collision = 1'b1;
      out_of_bounds = 1'b1;
      @(negedge clk);
      claw_collision = 1'b0;
      out_of_bounds = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (grabbed !== 1'b1 || grab_weight !== 2'd1) begin
         fails++;
         $display("FAIL coll_wins: got g=%b w=%0d expected 1 1",
                  grabbed, grab_weight);
      end
      base = ret_cnt;
      claw_collision = 1'b1;
      for (int i = 0; i < 3; i++) begin
         frame();
         m_len = (m_len > 4) ? m_len - 4 : 0;
         tests++;
         if (int'(topLeftY) !== exp_y() || busy !== 1'b1) begin
            fails++;
            $display("FAIL coll_ignored[%0d]: got %0d b=%b expected %0d 1",
                     i, topLeftY, busy, exp_y());
         end
      end
      frame();
      frame();
      claw_collision = 1'b0;
      tests++;
      if (ret_cnt - base != 1 || grabbed !== 1'b0) begin
         fails++;
         $display("FAIL coll_return: got r=%0d g=%b expected 1 0",
                  ret_cnt - base, grabbed);
      end
   endtask

   task automatic test_out_of_bounds();
      restart();
      fire_pulse();
      extend_n(4, 5);
      out_of_bounds = 1'b1;
      @(negedge clk);
      out_of_bounds = 1'b0;
      @(negedge clk);
      tests++;
      if (grabbed !== 1'b0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL oob: got g=%b b=%b expected 0 1", grabbed, busy);
      end
      frame();
      m_len = m_len - 8;
      tests++;
      if (int'(topLeftY) !== exp_y()) begin
         fails++;
         $display("FAIL oob_ret_y: got %0d expected %0d",
                  topLeftY, exp_y());
      end
   endtask

   task automatic test_start_level();
      int base;
      restart();
      fire_pulse();
      extend_n(3, 4);
      base = ret_cnt;
      start_level = 1'b1;
      @(negedge clk);
      start_level = 1'b0;
      tests++;
      if (topLeftX !== 11'sd280 || topLeftY !== 11'sd81 || busy !== 1'b0) begin
         fails++;
         $display("FAIL sl_extend: got %0d,%0d b=%b expected 280,81 0",
                  topLeftX, topLeftY, busy);
      end
      restart();
      fire_pulse();
      extend_n(5, 4);
      load_weight = 2'd2;
      claw_collision = 1'b1;
      @(negedge clk);
      claw_collision = 1'b0;
      @(negedge clk);
      frame();
      tests++;
      if (grabbed !== 1'b1) begin
         fails++;
         $display("FAIL sl_pre_grab: got %b expected 1", grabbed);
      end
      start_level = 1'b1;
      @(negedge clk);
      start_level = 1'b0;
      frame();
      frame();
      tests++;
      if (grabbed !== 1'b0 || ret_cnt != base || topLeftY !== 11'sd81) begin
         fails++;
         $display("FAIL sl_retract: got g=%b r=%0d y=%0d expected 0 0 81",
                  grabbed, ret_cnt - base, topLeftY);
      end
   endtask

   task automatic test_async_reset();
      restart();
      fire_pulse();
      extend_n(4, 5);
      load_weight = W_HEAVY;
      claw_collision = 1'b1;
      @(negedge clk);
      claw_collision = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (grabbed !== 1'b1 || grab_weight !== 2'd3) begin
         fails++;
         $display("FAIL ar_pre: got g=%b w=%0d expected 1 3",
                  grabbed, grab_weight);
      end
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      tests++;
      if (grabbed !== 1'b0 || grab_weight !== 2'd0 || busy !== 1'b0 ||
          topLeftX !== 11'sd280 || topLeftY !== 11'sd81) begin
         fails++;
         $display("FAIL async_reset: got g=%b w=%0d b=%b %0d,%0d expected 0 0 0 280,81",
                  grabbed, grab_weight, busy, topLeftX, topLeftY);
      end
      @(negedge clk);
      reset = 1'b0;
      model_clear();
   endtask

   initial begin
      test_reset();
      test_swing_basic();
      test_swing_limit();
      test_swing_random();
      test_extend_empty(2);
      test_extend_empty(int'($urandom_range(1, 15)));
      test_grab();
      test_collision_priority();
      test_out_of_bounds();
      test_start_level();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
